// File: rtl/masked_inv_sched_pkg.sv
// Shared types for the masked GF(2^8) inverter scheduler.
package masked_inv_sched_pkg;

    typedef logic [7:0] bv8_t;

    // Tag width carried in the in-flight pipeline; the top TAG_WIDTH must match.
    localparam int TAG_W = 5;

    typedef enum logic {
        SRC_S = 1'b0,
        SRC_K = 1'b1
    } src_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic             valid;
        src_e             src;
        logic [TAG_W-1:0] tag;
    } inflight_t;

endpackage

// File: rtl/masked_inv_sched_if.sv
// Requester, randomness, inverter and response signals of the scheduler.
interface masked_inv_sched_if #(
    parameter int NUM_SHARES = 2,
    parameter int TAG_WIDTH  = 5
);
    logic                    in_s_valid;
    logic [NUM_SHARES*8-1:0] in_s_data;
    logic [TAG_WIDTH-1:0]    in_s_tag;
    logic                    out_s_ready;
    logic                    in_k_valid;
    logic [NUM_SHARES*8-1:0] in_k_data;
    logic [TAG_WIDTH-1:0]    in_k_tag;
    logic                    out_k_ready;
    logic                    in_rand_valid;
    logic                    out_rand_take;
    logic                    in_flush;
    logic [NUM_SHARES*8-1:0] out_inv_a;
    logic [NUM_SHARES*8-1:0] in_inv_b;
    logic                    out_s_rsp_valid;
    logic [NUM_SHARES*8-1:0] out_s_rsp_data;
    logic [TAG_WIDTH-1:0]    out_s_rsp_tag;
    logic                    out_k_rsp_valid;
    logic [NUM_SHARES*8-1:0] out_k_rsp_data;
    logic [TAG_WIDTH-1:0]    out_k_rsp_tag;
    logic                    out_busy;

    modport slave (
        input  in_s_valid, in_s_data, in_s_tag, in_k_valid, in_k_data, in_k_tag,
               in_rand_valid, in_flush, in_inv_b,
        output out_s_ready, out_k_ready, out_rand_take, out_inv_a,
               out_s_rsp_valid, out_s_rsp_data, out_s_rsp_tag,
               out_k_rsp_valid, out_k_rsp_data, out_k_rsp_tag, out_busy
    );

    modport master (
        output in_s_valid, in_s_data, in_s_tag, in_k_valid, in_k_data, in_k_tag,
               in_rand_valid, in_flush, in_inv_b,
        input  out_s_ready, out_k_ready, out_rand_take, out_inv_a,
               out_s_rsp_valid, out_s_rsp_data, out_s_rsp_tag,
               out_k_rsp_valid, out_k_rsp_data, out_k_rsp_tag, out_busy
    );
endinterface

// File: rtl/masked_inv_sched_reg.sv
// Generic clearable register used for each in-flight tag slot.
module sched_reg #(
    parameter type T = logic
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    input  T     d,
    output T     q
);
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b)   q <= '0;
        else if (clr) q <= '0;
        else          q <= d;
    end
endmodule

// File: rtl/masked_inv_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
    import masked_inv_sched_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_b,
    input  logic en,
    input  logic req_s,
    input  logic req_k,
    output logic grant_s,
    output logic grant_k
);
    src_e last_grant;

    always_comb begin
        grant_s = 1'b0;
        grant_k = 1'b0;
        if (en) begin
            if (req_s && req_k) begin
                grant_s = (last_grant == SRC_K);
                grant_k = (last_grant == SRC_S);
            end else begin
                grant_s = req_s;
                grant_k = req_k;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b)       last_grant <= SRC_K;
        else if (grant_s) last_grant <= SRC_S;
        else if (grant_k) last_grant <= SRC_K;
    end
endmodule

// File: rtl/masked_inv_sched.sv
// Shares one fixed-latency masked inverter between the state and key S-box paths.
//   state | meaning
//   RUN   | issue allowed when randomness is present
//   DRAIN | no issue; down-counter waits out stale inverter results
module masked_inv_sched
    import masked_inv_sched_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int LATENCY    = 3,
    parameter int TAG_WIDTH  = TAG_W
) (
    input  logic             in_clock,
    input  logic             in_reset,
    masked_inv_sched_if.slave bus
);
    localparam int DW    = NUM_SHARES * 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    sched_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             issue_en, grant_s, grant_k, any_valid;
    logic             ret_s, ret_k;
    logic [DW-1:0]    inv_a, s_data_q, k_data_q;
    logic [TAG_WIDTH-1:0] s_tag_q, k_tag_q;
    inflight_t        slot_d [LATENCY+1];
    inflight_t        slot_q [LATENCY+1];
    inflight_t        last;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.in_flush) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = CNT_W'(LATENCY - 1);
        end else if (state == ST_DRAIN) begin
            if (cnt == '0) state_nxt = ST_RUN;
            else           cnt_nxt   = cnt - 1'b1;
        end
    end

    // Reset is folded in so ready/take read 0 while the block is held in reset.
    assign issue_en = in_reset && (state == ST_RUN) && !bus.in_flush && bus.in_rand_valid;

    rr_arb2 u_arb (
        .clk_sys (in_clock),
        .rst_b   (in_reset),
        .en      (issue_en),
        .req_s   (bus.in_s_valid),
        .req_k   (bus.in_k_valid),
        .grant_s (grant_s),
        .grant_k (grant_k)
    );

    assign bus.out_s_ready   = grant_s;
    assign bus.out_k_ready   = grant_k;
    assign bus.out_rand_take = grant_s | grant_k;

    // Operand only changes on a grant so idle cycles do not toggle the masked data.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset)    inv_a <= '0;
        else if (grant_s) inv_a <= bus.in_s_data;
        else if (grant_k) inv_a <= bus.in_k_data;
    end
    assign bus.out_inv_a = inv_a;

    assign slot_d[0] = '{valid: grant_s | grant_k,
                         src:   grant_k ? SRC_K : SRC_S,
                         tag:   grant_k ? bus.in_k_tag : bus.in_s_tag};

    for (genvar i = 1; i <= LATENCY; i++) begin : g_shift
        assign slot_d[i] = slot_q[i-1];
    end

    for (genvar i = 0; i <= LATENCY; i++) begin : g_slot
        sched_reg #(.T(inflight_t)) u_slot (
            .clk_sys (in_clock),
            .rst_b   (in_reset),
            .clr     (bus.in_flush),
            .d       (slot_d[i]),
            .q       (slot_q[i])
        );
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i <= LATENCY; i++) any_valid |= slot_q[i].valid;
    end
    assign bus.out_busy = any_valid || (state == ST_DRAIN);

    // A result landing in the flush cycle belongs to pre-flush work and is dropped.
    assign last  = slot_q[LATENCY];
    assign ret_s = last.valid && (last.src == SRC_S) && !bus.in_flush;
    assign ret_k = last.valid && (last.src == SRC_K) && !bus.in_flush;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            s_data_q <= '0;
            s_tag_q  <= '0;
            k_data_q <= '0;
            k_tag_q  <= '0;
        end else begin
            if (ret_s) begin
                s_data_q <= bus.in_inv_b;
                s_tag_q  <= last.tag;
            end
            if (ret_k) begin
                k_data_q <= bus.in_inv_b;
                k_tag_q  <= last.tag;
            end
        end
    end

    assign bus.out_s_rsp_valid = ret_s;
    assign bus.out_s_rsp_data  = ret_s ? bus.in_inv_b : s_data_q;
    assign bus.out_s_rsp_tag   = ret_s ? last.tag : s_tag_q;
    assign bus.out_k_rsp_valid = ret_k;
    assign bus.out_k_rsp_data  = ret_k ? bus.in_inv_b : k_data_q;
    assign bus.out_k_rsp_tag   = ret_k ? last.tag : k_tag_q;
endmodule

// File: tb/tb_masked_inv_sched.sv
// Bench for masked_inv_sched: inverter replaced by a LATENCY-cycle delay line, checked against a queue model.
module tb_masked_inv_sched;
    localparam int L  = 3;
    localparam int DW = 16;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masked_inv_sched_if #(.NUM_SHARES(2), .TAG_WIDTH(TW)) bus();

    masked_inv_sched #(.NUM_SHARES(2), .LATENCY(L), .TAG_WIDTH(TW)) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus.slave)
    );

    logic [DW-1:0] stub [L];
    always @(posedge clk) begin
        stub[0] <= bus.out_inv_a;
        for (int i = 1; i < L; i++) stub[i] <= stub[i-1];
    end
    assign bus.in_inv_b = stub[L-1];

    typedef struct {
        int            due;
        bit            is_k;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } op_t;

    op_t           pend[$];
    int            cyc;
    int            drain_until;
    bit            m_last_k;
    logic [DW-1:0] m_inv_a, m_s_data, m_k_data;
    logic [TW-1:0] m_s_tag, m_k_tag;
    bit            e_s_rdy, e_k_rdy, e_take, e_s_rv, e_k_rv, e_busy;
    logic [DW-1:0] e_inv_a;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic model_reset();
        pend.delete();
        drain_until = -1;
        m_last_k = 1'b1;
        m_inv_a = '0;
        m_s_data = '0;
        m_k_data = '0;
        m_s_tag = '0;
        m_k_tag = '0;
    endtask

    // One clock cycle: drive inputs, then compute what the scheduler must show in this cycle.
    task automatic cycle(input bit sv, input logic [DW-1:0] sd, input logic [TW-1:0] st,
                         input bit kv, input logic [DW-1:0] kd, input logic [TW-1:0] kt,
                         input bit rv, input bit fl);
        bit  issue;
        op_t keep[$];
        @(posedge clk);
        cyc++;
        #1;
        bus.in_s_valid = sv; bus.in_s_data = sd; bus.in_s_tag = st;
        bus.in_k_valid = kv; bus.in_k_data = kd; bus.in_k_tag = kt;
        bus.in_rand_valid = rv; bus.in_flush = fl;
        #1;
        issue   = (cyc > drain_until) && !fl && rv;
        e_s_rdy = issue && sv && (!kv || m_last_k);
        e_k_rdy = issue && kv && (!sv || !m_last_k);
        e_take  = e_s_rdy || e_k_rdy;
        e_inv_a = m_inv_a;
        e_busy  = (cyc <= drain_until) || (pend.size() != 0);
        e_s_rv  = 1'b0;
        e_k_rv  = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc && !fl) begin
                if (pend[i].is_k) begin
                    e_k_rv = 1'b1; m_k_data = pend[i].data; m_k_tag = pend[i].tag;
                end else begin
                    e_s_rv = 1'b1; m_s_data = pend[i].data; m_s_tag = pend[i].tag;
                end
            end
            if (pend[i].due != cyc) keep.push_back(pend[i]);
        end
        pend = keep;
        if (fl) begin
            pend.delete();
            drain_until = cyc + L;
        end
        if (e_s_rdy) begin
            pend.push_back('{cyc + L + 1, 1'b0, st, sd});
            m_inv_a = sd;
            m_last_k = 1'b0;
        end
        if (e_k_rdy) begin
            pend.push_back('{cyc + L + 1, 1'b1, kt, kd});
            m_inv_a = kd;
            m_last_k = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, 1, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_s_valid = 1; bus.in_s_data = 16'h1234; bus.in_s_tag = 5'd1;
        bus.in_k_valid = 1; bus.in_k_data = 16'h5678; bus.in_k_tag = 5'd2;
        bus.in_rand_valid = 1; bus.in_flush = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.out_s_ready, bus.out_k_ready, bus.out_rand_take, bus.out_s_rsp_valid,
             bus.out_k_rsp_valid, bus.out_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=000000", {bus.out_s_ready, bus.out_k_ready,
                     bus.out_rand_take, bus.out_s_rsp_valid, bus.out_k_rsp_valid, bus.out_busy});
        end
        n_checks++;
        if ({bus.out_inv_a, bus.out_s_rsp_data, bus.out_s_rsp_tag, bus.out_k_rsp_data,
             bus.out_k_rsp_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got inv_a=%h s=%h/%h k=%h/%h want all 0", bus.out_inv_a,
                     bus.out_s_rsp_data, bus.out_s_rsp_tag, bus.out_k_rsp_data, bus.out_k_rsp_tag);
        end
        bus.in_s_valid = 0;
        bus.in_k_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        int sc = 0;
        int kc = 0;
        bit want_s, want_k;
        for (int c = 0; c < 4; c++) begin
            cycle(1, DW'($urandom), TW'(sc + 1), 1, DW'($urandom), TW'(kc + 1), 1, 0);
            want_s = (c % 2 == 0);
            n_checks++;
            if (bus.out_s_ready !== want_s || bus.out_k_ready !== !want_s) begin
                n_fail++;
                $display("FAIL contention_grant c=%0d got s=%b k=%b want s=%b k=%b", c,
                         bus.out_s_ready, bus.out_k_ready, want_s, !want_s);
            end
            if (e_s_rdy) sc++;
            if (e_k_rdy) kc++;
        end
        for (int j = 0; j < 6; j++) begin
            idle(1);
            want_s = (j < 4) && (j % 2 == 0);
            want_k = (j < 4) && (j % 2 == 1);
            n_checks++;
            if (bus.out_s_rsp_valid !== want_s || bus.out_k_rsp_valid !== want_k) begin
                n_fail++;
                $display("FAIL contention_rsp j=%0d got s=%b k=%b want s=%b k=%b", j,
                         bus.out_s_rsp_valid, bus.out_k_rsp_valid, want_s, want_k);
            end
            if (j < 4) begin
                n_checks++;
                if ((want_s ? bus.out_s_rsp_tag : bus.out_k_rsp_tag) !== TW'(j / 2 + 1) ||
                    (want_s ? bus.out_s_rsp_data : bus.out_k_rsp_data) !== (want_s ? m_s_data : m_k_data)) begin
                    n_fail++;
                    $display("FAIL contention_payload j=%0d got s=%h/%0d k=%h/%0d want tag=%0d", j,
                             bus.out_s_rsp_data, bus.out_s_rsp_tag, bus.out_k_rsp_data,
                             bus.out_k_rsp_tag, j / 2 + 1);
                end
            end
        end
    endtask

    task automatic test_single();
        cycle(1, 16'h00A5, 5'd3, 0, '0, '0, 1, 0);
        n_checks++;
        if (bus.out_s_ready !== 1'b1 || bus.out_rand_take !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready got ready=%b take=%b want 1 1", bus.out_s_ready, bus.out_rand_take);
        end
        for (int j = 1; j <= 5; j++) begin
            idle(1);
            n_checks++;
            if (bus.out_s_rsp_valid !== (j == L + 1) || bus.out_k_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_valid j=%0d got s=%b k=%b want s=%b k=0", j,
                         bus.out_s_rsp_valid, bus.out_k_rsp_valid, j == L + 1);
            end
            if (j == L + 1) begin
                n_checks++;
                if (bus.out_s_rsp_data !== 16'h00A5 || bus.out_s_rsp_tag !== 5'd3) begin
                    n_fail++;
                    $display("FAIL single_payload got %h/%0d want 00a5/3", bus.out_s_rsp_data, bus.out_s_rsp_tag);
                end
            end
        end
    endtask

    task automatic test_starve();
        logic [DW-1:0] held;
        held = m_inv_a;
        for (int j = 0; j < 5; j++) begin
            cycle(1, DW'($urandom), 5'd9, 0, '0, '0, 0, 0);
            n_checks++;
            if (bus.out_s_ready !== 1'b0 || bus.out_rand_take !== 1'b0 || bus.out_inv_a !== held) begin
                n_fail++;
                $display("FAIL starve j=%0d got ready=%b take=%b inv_a=%h want 0 0 %h", j,
                         bus.out_s_ready, bus.out_rand_take, bus.out_inv_a, held);
            end
        end
        cycle(1, 16'h3C5A, 5'd9, 0, '0, '0, 1, 0);
        n_checks++;
        if (bus.out_s_ready !== 1'b1 || bus.out_rand_take !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_release got ready=%b take=%b want 1 1", bus.out_s_ready, bus.out_rand_take);
        end
        idle(L + 2);
        n_checks++;
        if (bus.out_inv_a !== 16'h3C5A || bus.out_s_rsp_data !== 16'h3C5A || bus.out_s_rsp_tag !== 5'd9) begin
            n_fail++;
            $display("FAIL starve_result got inv_a=%h rsp=%h/%0d want 3c5a 3c5a/9", bus.out_inv_a,
                     bus.out_s_rsp_data, bus.out_s_rsp_tag);
        end
    endtask

    task automatic test_flush();
        for (int j = 0; j < 3; j++) cycle(1, DW'($urandom), TW'(20 + j), 0, '0, '0, 1, 0);
        cycle(0, '0, '0, 0, '0, '0, 1, 1);
        for (int j = 0; j < L + 2; j++) begin
            idle(1);
            n_checks++;
            if (bus.out_s_rsp_valid !== 1'b0 || bus.out_k_rsp_valid !== 1'b0 || bus.out_busy !== (j < L)) begin
                n_fail++;
                $display("FAIL flush_drain j=%0d got s=%b k=%b busy=%b want 0 0 %b", j,
                         bus.out_s_rsp_valid, bus.out_k_rsp_valid, bus.out_busy, j < L);
            end
        end
        cycle(1, 16'hBEEF, 5'd7, 0, '0, '0, 1, 0);
        idle(L + 1);
        n_checks++;
        if (bus.out_s_rsp_valid !== 1'b1 || bus.out_s_rsp_data !== 16'hBEEF || bus.out_s_rsp_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL flush_after got v=%b %h/%0d want 1 beef/7", bus.out_s_rsp_valid,
                     bus.out_s_rsp_data, bus.out_s_rsp_tag);
        end
    endtask

    task automatic test_flush_valid();
        cycle(1, 16'h1111, 5'd1, 1, 16'h2222, 5'd2, 1, 1);
        n_checks++;
        if (bus.out_s_ready !== 1'b0 || bus.out_k_ready !== 1'b0 || bus.out_rand_take !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid got s=%b k=%b take=%b want 0 0 0", bus.out_s_ready,
                     bus.out_k_ready, bus.out_rand_take);
        end
        idle(L + 2);
        n_checks++;
        if (bus.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid_busy got=%b want=0", bus.out_busy);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 16'hAAAA, 5'd4, 0, '0, '0, 1, 0);
        cycle(0, '0, '0, 1, 16'h5555, 5'd5, 1, 0);
        bus.in_s_valid = 1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_s_ready, bus.out_k_ready, bus.out_rand_take, bus.out_s_rsp_valid,
             bus.out_k_rsp_valid, bus.out_busy} !== 6'b0 ||
            {bus.out_inv_a, bus.out_s_rsp_data, bus.out_s_rsp_tag, bus.out_k_rsp_data,
             bus.out_k_rsp_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b take=%b inv_a=%h s=%h k=%h want all 0", bus.out_busy,
                     bus.out_rand_take, bus.out_inv_a, bus.out_s_rsp_data, bus.out_k_rsp_data);
        end
        @(negedge clk);
        bus.in_s_valid = 0;
        bus.in_k_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < L + 2; j++) begin
            idle(1);
            n_checks++;
            if (bus.out_s_rsp_valid !== 1'b0 || bus.out_k_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale j=%0d got s=%b k=%b want 0 0", j, bus.out_s_rsp_valid,
                         bus.out_k_rsp_valid);
            end
        end
        cycle(1, 16'h0F0F, 5'd6, 1, 16'hF0F0, 5'd8, 1, 0);
        n_checks++;
        if (bus.out_s_ready !== 1'b1 || bus.out_k_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_tie got s=%b k=%b want 1 0", bus.out_s_ready, bus.out_k_ready);
        end
        idle(L + 2);
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            cycle($urandom_range(0, 1) == 1, DW'($urandom), TW'($urandom),
                  $urandom_range(0, 1) == 1, DW'($urandom), TW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            n_checks++;
            if ({bus.out_s_ready, bus.out_k_ready, bus.out_rand_take} !== {e_s_rdy, e_k_rdy, e_take}) begin
                n_fail++;
                $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc,
                         {bus.out_s_ready, bus.out_k_ready, bus.out_rand_take}, {e_s_rdy, e_k_rdy, e_take});
            end
            n_checks++;
            if ({bus.out_s_rsp_valid, bus.out_k_rsp_valid, bus.out_busy} !== {e_s_rv, e_k_rv, e_busy}) begin
                n_fail++;
                $display("FAIL rnd_status cyc=%0d got=%b want=%b", cyc,
                         {bus.out_s_rsp_valid, bus.out_k_rsp_valid, bus.out_busy}, {e_s_rv, e_k_rv, e_busy});
            end
            n_checks++;
            if (bus.out_inv_a !== e_inv_a) begin
                n_fail++;
                $display("FAIL rnd_inv_a cyc=%0d got=%h want=%h", cyc, bus.out_inv_a, e_inv_a);
            end
            n_checks++;
            if (bus.out_s_rsp_data !== m_s_data || bus.out_s_rsp_tag !== m_s_tag) begin
                n_fail++;
                $display("FAIL rnd_s_rsp cyc=%0d got=%h/%0d want=%h/%0d", cyc, bus.out_s_rsp_data,
                         bus.out_s_rsp_tag, m_s_data, m_s_tag);
            end
            n_checks++;
            if (bus.out_k_rsp_data !== m_k_data || bus.out_k_rsp_tag !== m_k_tag) begin
                n_fail++;
                $display("FAIL rnd_k_rsp cyc=%0d got=%h/%0d want=%h/%0d", cyc, bus.out_k_rsp_data,
                         bus.out_k_rsp_tag, m_k_data, m_k_tag);
            end
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_starve();
        test_flush();
        test_flush_valid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
